// File: rtl/alu_pkg.sv
// Shared definitions for the lab-2 ALU datapath: FSM states, opcodes, default widths.
package alu_pkg;

    localparam int unsigned M_DEF   = 4;
    localparam int unsigned OPW_DEF = 3;

    typedef enum logic [1:0] {
        CAP_A  = 2'd0,
        CAP_B  = 2'd1,
        CAP_OP = 2'd2,
        SALIDA = 2'd3
    } estado_t;

    // Opcode encodings consumed by the ALU
    localparam logic [OPW_DEF-1:0] OP_SUMA  = 3'd0;
    localparam logic [OPW_DEF-1:0] OP_RESTA = 3'd1;
    localparam logic [OPW_DEF-1:0] OP_AND   = 3'd2;
    localparam logic [OPW_DEF-1:0] OP_OR    = 3'd3;
    localparam logic [OPW_DEF-1:0] OP_EXP   = 3'd4;
    localparam logic [OPW_DEF-1:0] OP_XOR   = 3'd5;
    localparam logic [OPW_DEF-1:0] OP_SHL   = 3'd6;
    localparam logic [OPW_DEF-1:0] OP_SHR   = 3'd7;

    function automatic logic es_captura(input estado_t e);
        return (e != SALIDA);
    endfunction

endpackage

// File: rtl/sincronizador_pulso.sv
// Multi-flop synchronizer for an asynchronous button followed by a registered
// rising-edge detector producing a one-cycle pulse.
module sincronizador_pulso #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic boton,
    output logic pulso
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pulso  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], boton};
            prev_q <= sync_q[SYNC_STAGES-1];
            pulso  <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/captura_operandos.sv
// Operand-entry stage: captures A, B, opcode/carry on successive load presses and
// offers the bundle to the ALU through a valid/ready handshake.
module captura_operandos
    import alu_pkg::*;
#(
    parameter int unsigned M           = M_DEF,
    parameter int unsigned OPW         = OPW_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M-1:0]   switches,
    input  logic           sw_carry,
    input  logic           boton_carga,
    input  logic           boton_cancelar,
    input  logic           listo,
    output logic [M-1:0]   entrada1,
    output logic [M-1:0]   entrada2,
    output logic [OPW-1:0] operacion,
    output logic           carry_in,
    output logic           valido,
    output logic [1:0]     estado,
    output logic [7:0]     conteo
);

    logic    carga_p;
    logic    cancel_p;
    estado_t state_q;
    estado_t state_d;
    logic    cap_a_c;
    logic    cap_b_c;
    logic    cap_op_c;
    logic    transfer_c;

    sincronizador_pulso #(.SYNC_STAGES(SYNC_STAGES)) u_sync_carga (
        .clk   (clk),
        .rst_n (rst_n),
        .boton (boton_carga),
        .pulso (carga_p)
    );

    sincronizador_pulso #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cancel (
        .clk   (clk),
        .rst_n (rst_n),
        .boton (boton_cancelar),
        .pulso (cancel_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CAP_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and capture strobes; cancel wins over load, a ready transfer wins over cancel
    always_comb begin
        state_d    = state_q;
        cap_a_c    = 1'b0;
        cap_b_c    = 1'b0;
        cap_op_c   = 1'b0;
        transfer_c = 1'b0;
        case (state_q)
            CAP_A: begin
                if (cancel_p) begin
                    state_d = CAP_A;
                end else if (carga_p) begin
                    cap_a_c = 1'b1;
                    state_d = CAP_B;
                end
            end
            CAP_B: begin
                if (cancel_p) begin
                    state_d = CAP_A;
                end else if (carga_p) begin
                    cap_b_c = 1'b1;
                    state_d = CAP_OP;
                end
            end
            CAP_OP: begin
                if (cancel_p) begin
                    state_d = CAP_A;
                end else if (carga_p) begin
                    cap_op_c = 1'b1;
                    state_d  = SALIDA;
                end
            end
            SALIDA: begin
                if (listo) begin
                    transfer_c = 1'b1;
                    state_d    = CAP_A;
                end else if (cancel_p) begin
                    state_d = CAP_A;
                end
            end
            default: state_d = CAP_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entrada1  <= '0;
            entrada2  <= '0;
            operacion <= '0;
            carry_in  <= 1'b0;
            valido    <= 1'b0;
            conteo    <= 8'd0;
        end else begin
            if (cap_a_c) entrada1 <= switches;
            if (cap_b_c) entrada2 <= switches;
            if (cap_op_c) begin
                operacion <= switches[OPW-1:0];
                carry_in  <= sw_carry;
            end
            if (transfer_c) conteo <= conteo + 8'd1;
            // Registered copy of the SALIDA decode so valido tracks state_q exactly
            valido <= !es_captura(state_d);
        end
    end

    assign estado = 2'(state_q);

endmodule
